// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state encoding, the latency bounds and the address check.
// Imported by the responder top and its RAM sub-module.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 7;
    // Wide enough to hold LATENCY_MAX-1.
    localparam int CNT_W       = 3;

    // A request is bad when it is not word aligned or its word index
    // falls outside the array.
    function automatic logic addr_bad(input logic [31:0] addr, input int depth_words);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth_words));
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// CPU-side load/store request and response bundle.
// The CPU drives the master side; the responder owns the slave side.
// Both channels are valid/ready handshakes.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder_array.sv
// Synchronous word RAM with per-byte write enables and a registered read port.
// Latency: read data appears one edge after en_i; writes land on the same edge.
// No backpressure: the caller pulses en_i once per access.
module dmem_array #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk_i,
    input  logic                           en_i,
    input  logic                           we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
    input  logic [31:0]                    wdata_i,
    input  logic [3:0]                     be_i,
    output logic [31:0]                    rdata_o
);
    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Byte-masked write and read of the addressed word; the read register only
    // moves on an access so it holds its value for the whole response.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) begin
                        mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder in front of a word RAM.
// Latency: response valid exactly LATENCY edges after the accept edge.
// Backpressure: holds the response until rsp_ready; accepts nothing until then.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic               clk,
    input  logic               reset,
    dmem_responder_if.slave    bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept, access;
    logic               we_q;
    logic [31:0]        addr_q, wdata_q;
    logic [3:0]         be_q;
    logic               err_q, load_q;
    logic               req_bad, ram_en;
    logic [31:0]        ram_rdata;

    assign req_bad = addr_bad(addr_q, DEPTH_WORDS);
    // A reset on the access edge must squash the store, so the RAM is gated here.
    assign ram_en  = access && !req_bad && !reset;

    // Next-state logic. The access always happens from BUSY on the edge where
    // the counter reads zero, which lands it LATENCY edges after accept for
    // every LATENCY including 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    access  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latency counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture on accept; request inputs are ignored at all other times.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
        end
    end

    // Response qualifiers, registered on the access edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q  <= 1'b0;
            load_q <= 1'b0;
        end else if (access) begin
            err_q  <= req_bad;
            load_q <= !we_q && !req_bad;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk_i   (clk),
        .en_i    (ram_en),
        .we_i    (we_q),
        .idx_i   (addr_q[AW+1:2]),
        .wdata_i (wdata_q),
        .be_i    (be_q),
        .rdata_o (ram_rdata)
    );

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_err   = bus.rsp_valid && err_q;
    assign bus.rsp_rdata = (bus.rsp_valid && load_q) ? ram_rdata : 32'h0;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed steps plus randomized traffic on a
// LATENCY=2 instance, and latency checks on LATENCY=1 and LATENCY=7 instances.
// A word-array reference model supplies every expected load value.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic        rv [3];
    logic        rwe [3];
    logic [31:0] raddr [3];
    logic [31:0] rwd [3];
    logic [3:0]  rbe [3];
    logic        rrdy [3];
    logic        o_rdy [3];
    logic        o_vld [3];
    logic        o_err [3];
    logic [31:0] o_rd [3];

    dmem_responder_if bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_bus
        assign bus[g].req_valid = rv[g];
        assign bus[g].req_we    = rwe[g];
        assign bus[g].req_addr  = raddr[g];
        assign bus[g].req_wdata = rwd[g];
        assign bus[g].req_be    = rbe[g];
        assign bus[g].rsp_ready = rrdy[g];
        assign o_rdy[g] = bus[g].req_ready;
        assign o_vld[g] = bus[g].rsp_valid;
        assign o_err[g] = bus[g].rsp_err;
        assign o_rd[g]  = bus[g].rsp_rdata;
    end

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_l2 (.clk(clk), .reset(reset), .bus(bus[0]));
    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_l1 (.clk(clk), .reset(reset), .bus(bus[1]));
    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(7)) u_l7 (.clk(clk), .reset(reset), .bus(bus[2]));

    // Reference model: the first 64 words, written before any random load.
    logic [31:0] ref_mem [64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] m = old;
        for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = wd[8*b +: 8];
        return m;
    endfunction

    // Drive one request and see it accepted on the next edge.
    task automatic issue(input int k, input bit we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        @(negedge clk);
        rv[k] = 1'b1; rwe[k] = we; raddr[k] = addr; rwd[k] = wd; rbe[k] = be;
        @(posedge clk); #1;
        rv[k] = 1'b0;
        rwe[k] = 1'($urandom); raddr[k] = $urandom; rwd[k] = $urandom; rbe[k] = 4'($urandom);
    endtask

    // Full transaction: request, measured latency, held response, release.
    // With poke set, a competing store to the same address is presented while
    // the response is held; it must never be taken.
    task automatic txn(input int k, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input int hold, input bit poke, input string tag,
                       input logic [31:0] exp_rd, input bit exp_err, input int exp_lat);
        int lat = 0;
        @(negedge clk);
        chk({tag, "_ready_idle"}, 32'(o_rdy[k]), 32'd1);
        issue(k, we, addr, wd, be);
        while (o_vld[k] !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_err"}, 32'(o_err[k]), 32'(exp_err));
        chk({tag, "_rdata"}, o_rd[k], exp_rd);
        chk({tag, "_ready_resp"}, 32'(o_rdy[k]), 32'd0);
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                rv[k] = 1'b1; rwe[k] = 1'b1; raddr[k] = addr; rwd[k] = ~exp_rd; rbe[k] = 4'hF;
            end
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 32'(o_vld[k]), 32'd1);
            chk({tag, "_hold_rdata"}, o_rd[k], exp_rd);
            chk({tag, "_hold_ready"}, 32'(o_rdy[k]), 32'd0);
        end
        rrdy[k] = 1'b1;
        @(posedge clk); #1;
        rrdy[k] = 1'b0;
        rv[k] = 1'b0;
        chk({tag, "_released_valid"}, 32'(o_vld[k]), 32'd0);
        chk({tag, "_released_ready"}, 32'(o_rdy[k]), 32'd1);
    endtask

    initial begin
        int cyc;
        for (int k = 0; k < 3; k++) begin
            rv[k] = 1'b0; rwe[k] = 1'b0; raddr[k] = '0; rwd[k] = '0; rbe[k] = '0; rrdy[k] = 1'b0;
        end

        // Reset state.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(o_rdy[0]), 32'd1);
        chk("rst_valid", 32'(o_vld[0]), 32'd0);
        chk("rst_err", 32'(o_err[0]), 32'd0);
        chk("rst_rdata", o_rd[0], 32'd0);
        reset = 1'b0;

        // Basic store/load and byte enables.
        txn(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0, 1'b0, "init0", 32'h0, 1'b0, 2);
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, "st10", 32'h0, 1'b0, 2);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, "ld10", 32'hDEADBEEF, 1'b0, 2);
        txn(0, 1'b1, 32'h10, 32'h00000055, 4'b0001, 0, 1'b0, "st10_be", 32'h0, 1'b0, 2);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, "ld10_be", 32'hDEADBE55, 1'b0, 2);
        txn(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, 1'b0, "st10_be0", 32'h0, 1'b0, 2);

        // Error cases.
        txn(0, 1'b0, 32'h13, 32'h0, 4'h0, 0, 1'b0, "ld13_misal", 32'h0, 1'b1, 2);
        txn(0, 1'b1, 32'h400, 32'h11111111, 4'hF, 0, 1'b0, "st400_range", 32'h0, 1'b1, 2);
        txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, "ld0_after_err", 32'hCAFEF00D, 1'b0, 2);

        // Backpressure with a competing request held during the response.
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b1, "bp_ld10", 32'hDEADBE55, 1'b0, 2);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, "bp_check", 32'hDEADBE55, 1'b0, 2);

        // Reset one edge after accept drops the store.
        txn(0, 1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, 0, 1'b0, "st20", 32'h0, 1'b0, 2);
        issue(0, 1'b1, 32'h20, 32'h12345678, 4'hF);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rbusy_ready", 32'(o_rdy[0]), 32'd1);
        chk("rbusy_valid", 32'(o_vld[0]), 32'd0);
        chk("rbusy_rdata", o_rd[0], 32'd0);
        repeat (4) begin
            @(posedge clk); #1;
            chk("rbusy_no_rsp", 32'(o_vld[0]), 32'd0);
        end
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, "ld20_a", 32'hA5A5A5A5, 1'b0, 2);

        // Reset landing on the access edge also drops the store.
        issue(0, 1'b1, 32'h20, 32'h87654321, 4'hF);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("racc_valid", 32'(o_vld[0]), 32'd0);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, "ld20_b", 32'hA5A5A5A5, 1'b0, 2);

        // Reset during the response keeps the committed store.
        issue(0, 1'b1, 32'h24, 32'h0BADF00D, 4'hF);
        cyc = 0;
        while (o_vld[0] !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rresp_reached", 32'(o_vld[0]), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rresp_valid", 32'(o_vld[0]), 32'd0);
        chk("rresp_err", 32'(o_err[0]), 32'd0);
        txn(0, 1'b0, 32'h24, 32'h0, 4'h0, 0, 1'b0, "ld24", 32'h0BADF00D, 1'b0, 2);

        // Random traffic against the reference model.
        for (int w = 0; w < 64; w++) begin
            ref_mem[w] = $urandom;
            txn(0, 1'b1, 32'(w * 4), ref_mem[w], 4'hF, 0, 1'b0, "rinit", 32'h0, 1'b0, 2);
        end
        for (int n = 0; n < 120; n++) begin
            int kind = $urandom_range(0, 9);
            int w = $urandom_range(0, 63);
            bit we = 1'($urandom);
            logic [31:0] wd = $urandom;
            logic [3:0] be = 4'($urandom);
            int hold = $urandom_range(0, 2);
            logic [31:0] addr;
            if (kind == 0) begin
                addr = 32'(w * 4 + $urandom_range(1, 3));
                txn(0, we, addr, wd, be, hold, 1'b0, "rnd_misal", 32'h0, 1'b1, 2);
            end else if (kind == 1) begin
                addr = 32'((256 + $urandom_range(0, 4000)) * 4);
                txn(0, we, addr, wd, be, hold, 1'b0, "rnd_range", 32'h0, 1'b1, 2);
            end else if (we) begin
                txn(0, 1'b1, 32'(w * 4), wd, be, hold, 1'b0, "rnd_st", 32'h0, 1'b0, 2);
                ref_mem[w] = merge(ref_mem[w], wd, be);
            end else begin
                txn(0, 1'b0, 32'(w * 4), wd, be, hold, 1'b0, "rnd_ld", ref_mem[w], 1'b0, 2);
            end
        end

        // Latency extremes.
        txn(1, 1'b1, 32'h40, 32'h01020304, 4'hF, 0, 1'b0, "l1_st", 32'h0, 1'b0, 1);
        txn(1, 1'b0, 32'h40, 32'h0, 4'h0, 1, 1'b0, "l1_ld", 32'h01020304, 1'b0, 1);
        txn(2, 1'b1, 32'h44, 32'hA0B0C0D0, 4'hF, 0, 1'b0, "l7_st", 32'h0, 1'b0, 7);
        txn(2, 1'b0, 32'h44, 32'h0, 4'h0, 1, 1'b0, "l7_ld", 32'hA0B0C0D0, 1'b0, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
